// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - pipeline and backing-memory bus bundle for data_cache
interface data_cache_if #(
  parameter int WIDTH = 32
);
  // pipeline memory-stage side
  logic             cpu_req;
  logic             cpu_we;
  logic [2:0]       modeBU;
  logic [WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic [WIDTH-1:0] cpu_rdata;
  logic             stall;

  // backing data memory side
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  // environment view: the pipeline issuing accesses and the memory answering them
  modport master (
    output cpu_req, cpu_we, modeBU, cpu_addr, cpu_wdata,
    input  cpu_rdata, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ready
  );

  // cache view
  modport slave (
    input  cpu_req, cpu_we, modeBU, cpu_addr, cpu_wdata,
    output cpu_rdata, stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ready
  );
endinterface

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache
module data_cache #(
  parameter int WIDTH = 32,
  parameter int SETS  = 256
) (
  input  logic        clk,
  input  logic        rst,
  data_cache_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = WIDTH - IDX - 2;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR, RESP} state_t;

  state_t state, state_next;

  logic [SETS-1:0]  valid;
  logic [TAGW-1:0]  tags  [SETS];
  logic [WIDTH-1:0] lines [SETS];

  // request held by the miss/store sequence
  logic [WIDTH-1:0] l_addr;
  logic [2:0]       l_mode;
  logic             l_we;
  logic [WIDTH-1:0] cap_word;

  // registered memory-side request
  logic             req_q;
  logic             we_q;
  logic [WIDTH-1:0] maddr_q;
  logic [WIDTH-1:0] mwdata_q;
  logic [3:0]       be_q;

  logic [IDX-1:0]   idx, l_idx;
  logic [TAGW-1:0]  tag, l_tag;
  logic [1:0]       off;
  logic             mode_ok, op, hit, l_hit;
  logic             stall_c;
  logic [WIDTH-1:0] rdata_c;

  // Select the addressed lane (offset 0 is the most significant byte) and extend it.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] mode,
                                         input logic [1:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    case (o)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = o[1] ? w[15:0] : w[31:16];
    case (mode)
      3'b001:  extend = w;
      3'b010:  extend = {{16{h[15]}}, h};
      3'b011:  extend = {{24{b[7]}}, b};
      3'b100:  extend = {16'h0000, h};
      3'b101:  extend = {24'h000000, b};
      default: extend = 32'h0;
    endcase
  endfunction

  // Byte enables for a store; unsigned modes store exactly like their signed twins.
  function automatic logic [3:0] lanes(input logic [2:0] mode, input logic [1:0] o);
    case (mode)
      3'b001:         lanes = 4'b1111;
      3'b010, 3'b100: lanes = o[1] ? 4'b0011 : 4'b1100;
      3'b011, 3'b101: lanes = 4'b1000 >> o;
      default:        lanes = 4'b0000;
    endcase
  endfunction

  // Move right-aligned store data into the lanes it will occupy in the memory word.
  function automatic logic [31:0] place(input logic [31:0] w, input logic [2:0] mode,
                                        input logic [1:0] o);
    case (mode)
      3'b001:         place = w;
      3'b010, 3'b100: place = o[1] ? {16'h0000, w[15:0]} : {w[15:0], 16'h0000};
      3'b011, 3'b101: place = {w[7:0], 24'h000000} >> {o, 3'b000};
      default:        place = 32'h0;
    endcase
  endfunction

  assign idx     = bus.cpu_addr[IDX+1:2];
  assign tag     = bus.cpu_addr[WIDTH-1:IDX+2];
  assign off     = bus.cpu_addr[1:0];
  assign l_idx   = l_addr[IDX+1:2];
  assign l_tag   = l_addr[WIDTH-1:IDX+2];
  assign mode_ok = (bus.modeBU >= 3'b001) && (bus.modeBU <= 3'b101);
  assign op      = bus.cpu_req && mode_ok;
  assign hit     = valid[idx] && (tags[idx] == tag);
  assign l_hit   = valid[l_idx] && (tags[l_idx] == l_tag);

  assign bus.stall     = stall_c;
  assign bus.cpu_rdata = rdata_c;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;
  assign bus.mem_be    = be_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, stall and load result; load hits answer in the same cycle
  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    rdata_c    = '0;
    case (state)
      IDLE: begin
        if (op) begin
          if (bus.cpu_we) begin
            stall_c    = 1'b1;
            state_next = WR;
          end else if (hit) begin
            rdata_c = extend(lines[idx], bus.modeBU, off);
          end else begin
            stall_c    = 1'b1;
            state_next = RD_MISS;
          end
        end
      end
      RD_MISS, WR: begin
        stall_c = 1'b1;
        if (bus.mem_ready) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
        if (!l_we) rdata_c = extend(cap_word, l_mode, l_addr[1:0]);
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latching, memory-side request registers, valid bits and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      l_addr     <= '0;
      l_mode     <= '0;
      l_we       <= 1'b0;
      cap_word   <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
      be_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op && !bus.cpu_we && hit) begin
            hit_count <= hit_count + 32'd1;
          end else if (op) begin
            if (!bus.cpu_we) miss_count <= miss_count + 32'd1;
            l_addr   <= bus.cpu_addr;
            l_mode   <= bus.modeBU;
            l_we     <= bus.cpu_we;
            req_q    <= 1'b1;
            we_q     <= bus.cpu_we;
            maddr_q  <= {bus.cpu_addr[WIDTH-1:2], 2'b00};
            mwdata_q <= bus.cpu_we ? place(bus.cpu_wdata, bus.modeBU, off) : '0;
            be_q     <= bus.cpu_we ? lanes(bus.modeBU, off) : 4'b1111;
          end
        end
        RD_MISS, WR: begin
          if (bus.mem_ready) begin
            if (state == RD_MISS) begin
              valid[l_idx] <= 1'b1;
              cap_word     <= bus.mem_rdata;
            end
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            be_q     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line array: fills on read-miss completion, byte merges on store hits only
  always_ff @(posedge clk) begin
    if (!rst && bus.mem_ready) begin
      if (state == RD_MISS) begin
        tags[l_idx]  <= l_tag;
        lines[l_idx] <= bus.mem_rdata;
      end else if (state == WR && l_hit) begin
        for (int k = 0; k < 4; k++) begin
          if (be_q[k]) lines[l_idx][8*k +: 8] <= mwdata_q[8*k +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - self-checking bench for data_cache
module tb_data_cache;
  localparam int WIDTH = 32;
  localparam int SETS  = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  data_cache_if #(.WIDTH(WIDTH)) bus ();

  data_cache #(.WIDTH(WIDTH), .SETS(SETS)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: backing memory by word address, resident word per set, counts
  logic [31:0] backing  [int];
  int          resident [int];
  int          exp_hits = 0;
  int          exp_miss = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", name, obs, expv);
    end
  endtask

  function automatic logic [31:0] mem_word(input int waddr);
    if (backing.exists(waddr)) return backing[waddr];
    return 32'(waddr) * 32'h9E37_79B1;
  endfunction

  function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [2:0] m,
                                           input logic [1:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * (3 - int'(o))));
    h = 16'(w >> (o >= 2'd2 ? 0 : 16));
    case (m)
      3'd1:    return w;
      3'd2:    return 32'($signed(h));
      3'd3:    return 32'($signed(b));
      3'd4:    return 32'(h);
      3'd5:    return 32'(b);
      default: return 32'h0;
    endcase
  endfunction

  // One pipeline access; lat = RD_MISS/WR cycle on which the memory answers.
  task automatic access(input bit we, input logic [2:0] m, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat,
                        output logic [31:0] rd_o, output int stall_o);
    int          waddr    = int'(addr >> 2);
    int          idx      = waddr % SETS;
    logic [1:0]  o        = addr[1:0];
    bit          valid_op = (m >= 3'd1) && (m <= 3'd5);
    bit          is_hit   = resident.exists(idx) && (resident[idx] == waddr);
    logic [31:0] exp_rd   = 32'h0;
    logic [31:0] exp_wd   = 32'h0;
    logic [3:0]  exp_be   = 4'h0;
    logic [31:0] w;
    int          exp_stall;
    int          stalls = 0, memcyc = 0, writes = 0, reads = 0;
    bit          done = 1'b0;

    if (!valid_op || (!we && is_hit)) exp_stall = 0;
    else                              exp_stall = lat + 1;
    if (valid_op && !we) exp_rd = ext_load(mem_word(waddr), m, o);
    case (m)
      3'd1:       begin exp_be = 4'hF; exp_wd = wd; end
      3'd2, 3'd4: begin exp_be = o[1] ? 4'h3 : 4'hC; exp_wd = (wd & 32'hFFFF) << (o[1] ? 0 : 16); end
      3'd3, 3'd5: begin exp_be = 4'(8 >> o); exp_wd = (wd & 32'hFF) << (8 * (3 - int'(o))); end
      default:    ;
    endcase

    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.modeBU    = m;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    rd_o = 32'hx;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (!bus.stall) begin
        rd_o = bus.cpu_rdata;
        done = 1'b1;
        chk("mem_req_low_when_not_stalled", bus.mem_req, 32'h0);
      end else begin
        stalls++;
        if (bus.mem_req) begin
          memcyc++;
          if (memcyc == lat) begin
            chk("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
            chk("mem_we", bus.mem_we, we);
            if (we) begin
              chk("mem_be", bus.mem_be, exp_be);
              chk("mem_wdata", bus.mem_wdata, exp_wd);
              w = mem_word(waddr);
              for (int k = 0; k < 4; k++)
                if (bus.mem_be[k]) w[8*k +: 8] = bus.mem_wdata[8*k +: 8];
              backing[waddr] = w;
              writes++;
            end else begin
              bus.mem_rdata = mem_word(waddr);
              reads++;
            end
            bus.mem_ready = 1'b1;
          end
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
    stall_o = stalls;
    chk("access_completed", done, 1);
    chk("cpu_rdata", rd_o, exp_rd);
    chk("stall_cycles", stalls, exp_stall);
    chk("mem_writes", writes, (valid_op && we) ? 1 : 0);
    chk("mem_reads", reads, (valid_op && !we && !is_hit) ? 1 : 0);

    if (valid_op && !we) begin
      if (is_hit) exp_hits++;
      else begin exp_miss++; resident[idx] = waddr; end
    end

    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_miss);
  endtask

  logic [31:0] rd;
  int          st;
  int          h0, m0;
  logic [31:0] addr;
  logic [2:0]  m;
  bit          we;
  int          r;

  initial begin
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.modeBU    = 3'd1;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);

    // read miss then hit
    backing[32'h10000 >> 2] = 32'h1122_3344;
    access(0, 3'd1, 32'h10000, 0, 3, rd, st);
    chk("tp_miss_stall4", st, 4);
    chk("tp_miss_data", rd, 32'h1122_3344);
    chk("tp_miss_count1", miss_count, 1);
    access(0, 3'd1, 32'h10000, 0, 1, rd, st);
    chk("tp_hit_stall0", st, 0);
    chk("tp_hit_data", rd, 32'h1122_3344);
    chk("tp_hit_count1", hit_count, 1);

    // extension on a cached word
    access(1, 3'd1, 32'h10000, 32'h8001_33F4, 2, rd, st);
    access(0, 3'd3, 32'h10003, 0, 1, rd, st); chk("tp_lb", rd, 32'hFFFF_FFF4);
    access(0, 3'd5, 32'h10003, 0, 1, rd, st); chk("tp_lbu", rd, 32'h0000_00F4);
    access(0, 3'd2, 32'h10000, 0, 1, rd, st); chk("tp_lh", rd, 32'hFFFF_8001);
    access(0, 3'd4, 32'h10000, 0, 1, rd, st); chk("tp_lhu", rd, 32'h0000_8001);
    access(0, 3'd2, 32'h10002, 0, 1, rd, st); chk("tp_lh2", rd, 32'h0000_33F4);

    // store hit byte merge
    access(1, 3'd3, 32'h10001, 32'h0000_00AB, 1, rd, st);
    access(0, 3'd1, 32'h10000, 0, 1, rd, st);
    chk("tp_store_hit_merge", rd, 32'h80AB_33F4);
    chk("tp_store_hit_is_hit", st, 0);

    // store miss does not allocate
    m0 = exp_miss;
    access(1, 3'd1, 32'h20000, 32'hDEAD_BEEF, 2, rd, st);
    access(0, 3'd1, 32'h20000, 0, 2, rd, st);
    chk("tp_store_miss_then_load_miss", miss_count, m0 + 1);
    chk("tp_store_miss_data", rd, 32'hDEAD_BEEF);

    // conflict in one set
    h0 = exp_hits; m0 = exp_miss;
    access(0, 3'd1, 32'h10000, 0, 2, rd, st);
    access(0, 3'd1, 32'h10000 + 4 * SETS, 0, 2, rd, st);
    access(0, 3'd1, 32'h10000, 0, 2, rd, st);
    chk("tp_conflict_misses", miss_count, m0 + 3);
    chk("tp_conflict_hits", hit_count, h0);

    // randomized traffic against the model
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      addr = 32'h10000 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 1) * SETS * 4
             + $urandom_range(0, 3);
      if (r == 0) begin
        @(negedge clk);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("stray_ready_stall", bus.stall, 0);
        chk("stray_ready_mem_req", bus.mem_req, 0);
      end else begin
        m  = (r == 1) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
        we = ($urandom_range(0, 2) == 0);
        access(we, m, addr, $urandom, $urandom_range(1, 4), rd, st);
      end
    end

    // reset while a miss is outstanding, with the fill arriving on the reset edge
    access(0, 3'd1, 32'h10040, 0, 1, rd, st);
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.modeBU   = 3'd1;
    bus.cpu_addr = 32'h30000;
    @(negedge clk);
    #1;
    chk("rstmiss_req_active", bus.mem_req, 1);
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    bus.cpu_req   = 1'b0;
    @(negedge clk);
    rst           = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    chk("rstmiss_mem_req", bus.mem_req, 0);
    chk("rstmiss_stall", bus.stall, 0);
    chk("rstmiss_hit_count", hit_count, 0);
    chk("rstmiss_miss_count", miss_count, 0);
    resident.delete();
    exp_hits = 0;
    exp_miss = 0;
    access(0, 3'd1, 32'h10040, 0, 2, rd, st);
    chk("rstmiss_cached_now_misses", miss_count, 1);
    access(0, 3'd1, 32'h30000, 0, 2, rd, st);
    chk("rstmiss_fill_discarded", miss_count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
